// File: rtl/dsp_pkg.sv
// -----------------------------------------------------------------------------
// dsp_pkg
// Definitions shared between dsp_core and its program sequencer: the
// instruction word layout, opcode encodings, the NOP word and the default
// pipeline depth that sits behind instruction issue.
// No ports (package).
// -----------------------------------------------------------------------------
package dsp_pkg;

    localparam int INSTR_WIDTH     = 26;
    localparam int OPCODE_WIDTH    = 6;
    localparam int OPER_ADDR_WIDTH = 10;

    // read, ex1, ex2, writeback
    localparam int DRAIN_CYCLES    = 4;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_NOP   = 6'h00,
        OP_LOAD  = 6'h01,
        OP_MAC   = 6'h02,
        OP_ADD   = 6'h03,
        OP_MUL   = 6'h04,
        OP_STORE = 6'h05
    } opcode_t;

    typedef struct packed {
        opcode_t                    opcode;
        logic [OPER_ADDR_WIDTH-1:0] sample_addr;
        logic [OPER_ADDR_WIDTH-1:0] param_addr;
    } instr_t;

    // The core treats the all-zero word as a no-operation.
    localparam instr_t INSTR_NOP = '0;

endpackage

// File: rtl/dsp_program_sequencer.sv
// -----------------------------------------------------------------------------
// dsp_program_sequencer
// Per-sample instruction sequencer for one dsp_core. A sample_start strobe
// accepted while idle reads prog_len words from a synchronous program RAM and
// hands them to the core one per clock, then issues NOPs while the core
// pipeline drains and pulses done in the first idle cycle.
//
// Optional feature macro: DSP_PROGRAM_SWAP_EN (double-buffered program banks).
//
// Ports
//   clk, reset_n     clock; asynchronous active-low reset
//   i_sample_start   1-cycle strobe, starts a frame when idle
//   i_prog_len       instruction count, captured on an accepted start
//                    (values above 2**PROG_ADDR_WIDTH are clamped)
//   o_prog_rd_addr   program RAM address (MSB = active bank with swap enabled)
//   o_prog_rd_en     program RAM read enable
//   i_prog_rd_data   program RAM data, valid one cycle after address/enable
//   o_instruction    instruction to dsp_core, NOP when not issuing
//   o_busy           high from the cycle after an accepted start until done
//   o_done           1-cycle pulse when the last instruction left writeback
//   o_overrun        sticky, set by a start while busy
//   i_overrun_clr    clears o_overrun (a simultaneous new overrun wins)
//   i_swap_req       (swap only) request a bank toggle at the next start
//   o_swap_ack       (swap only) pulses the cycle after the toggling start
// -----------------------------------------------------------------------------
module dsp_program_sequencer #(
    parameter int INSTR_WIDTH     = dsp_pkg::INSTR_WIDTH,
    parameter int PROG_ADDR_WIDTH = 10,
    parameter int DRAIN_CYCLES    = dsp_pkg::DRAIN_CYCLES
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_sample_start,
    input  logic [PROG_ADDR_WIDTH:0]   i_prog_len,
`ifdef DSP_PROGRAM_SWAP_EN
    output logic [PROG_ADDR_WIDTH:0]   o_prog_rd_addr,
    input  logic                       i_swap_req,
    output logic                       o_swap_ack,
`else
    output logic [PROG_ADDR_WIDTH-1:0] o_prog_rd_addr,
`endif
    output logic                       o_prog_rd_en,
    input  logic [INSTR_WIDTH-1:0]     i_prog_rd_data,
    output logic [INSTR_WIDTH-1:0]     o_instruction,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_overrun,
    input  logic                       i_overrun_clr
);
    import dsp_pkg::*;

    // Drain lasts DRAIN_CYCLES+2 cycles so that done lands exactly when the
    // final word has left writeback; the counter runs 0..DRAIN_CYCLES+1.
    localparam int                       CNT_W      = $clog2(DRAIN_CYCLES + 2);
    localparam logic [CNT_W-1:0]         DRAIN_LAST = CNT_W'(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0]         CNT_ONE    = CNT_W'(1);
    localparam logic [PROG_ADDR_WIDTH-1:0] PC_ONE   = PROG_ADDR_WIDTH'(1);
    localparam logic [PROG_ADDR_WIDTH:0] MAX_LEN    = {1'b1, {PROG_ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } seq_state_t;

    seq_state_t                 r_state;
    seq_state_t                 w_next_state;
    logic [PROG_ADDR_WIDTH-1:0] r_pc;
    logic [PROG_ADDR_WIDTH-1:0] r_last;
    logic [CNT_W-1:0]           r_drain_cnt;
    logic                       r_issue_vld;
    logic                       r_done;
    logic                       r_overrun;

    logic                       w_start_acc;
    logic                       w_start_busy;
    logic                       w_len_zero;
    logic                       w_pc_last;
    logic                       w_drain_last;
    logic [PROG_ADDR_WIDTH:0]   w_len_clamped;
    logic [PROG_ADDR_WIDTH-1:0] w_rd_addr_lo;

    assign w_start_acc   = i_sample_start && (r_state == S_IDLE);
    assign w_start_busy  = i_sample_start && (r_state != S_IDLE);
    assign w_len_zero    = (i_prog_len == '0);
    assign w_len_clamped = (i_prog_len > MAX_LEN) ? MAX_LEN : i_prog_len;
    assign w_pc_last     = (r_pc == r_last);
    assign w_drain_last  = (r_drain_cnt == DRAIN_LAST);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start_acc)  w_next_state = w_len_zero ? S_DRAIN : S_RUN;
            S_RUN:   if (w_pc_last)    w_next_state = S_DRAIN;
            S_DRAIN: if (w_drain_last) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        o_prog_rd_en = 1'b0;
        w_rd_addr_lo = '0;
        o_busy       = 1'b0;
        case (r_state)
            S_RUN: begin
                o_prog_rd_en = 1'b1;
                w_rd_addr_lo = r_pc;
                o_busy       = 1'b1;
            end
            S_DRAIN: o_busy = 1'b1;
            default: ;
        endcase
        // Gate on the delayed enable so the RAM's held output is never re-issued.
        o_instruction = r_issue_vld ? i_prog_rd_data : INSTR_WIDTH'(INSTR_NOP);
    end

    // Program counter and drain counter. The last-address register keeps the
    // full 2**PROG_ADDR_WIDTH length representable: its low bits minus one
    // wrap to the top address, and pc saturates there instead of wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc        <= '0;
            r_last      <= '0;
            r_drain_cnt <= '0;
        end else if (w_start_acc) begin
            r_pc        <= '0;
            r_last      <= w_len_clamped[PROG_ADDR_WIDTH-1:0] - PC_ONE;
            r_drain_cnt <= '0;
        end else begin
            if ((r_state == S_RUN) && !w_pc_last) begin
                r_pc <= r_pc + PC_ONE;
            end
            if ((r_state == S_DRAIN) && !w_drain_last) begin
                r_drain_cnt <= r_drain_cnt + CNT_ONE;
            end
        end
    end

    // Issue-valid, done pulse and sticky overrun
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_issue_vld <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_issue_vld <= (r_state == S_RUN);
            r_done      <= (r_state == S_DRAIN) && w_drain_last;
            if (w_start_busy) begin
                r_overrun <= 1'b1;
            end else if (i_overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_done    = r_done;
    assign o_overrun = r_overrun;

`ifdef DSP_PROGRAM_SWAP_EN
    logic r_bank;
    logic r_pending;
    logic r_swap_ack;

    // The bank toggles on the accepting edge so the frame's first read already
    // uses the new bank. A request arriving together with that start is kept
    // pending for the following frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bank     <= 1'b0;
            r_pending  <= 1'b0;
            r_swap_ack <= 1'b0;
        end else begin
            r_swap_ack <= w_start_acc && r_pending;
            if (w_start_acc && r_pending) begin
                r_bank    <= ~r_bank;
                r_pending <= i_swap_req;
            end else if (i_swap_req) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign o_prog_rd_addr = {r_bank, w_rd_addr_lo};
    assign o_swap_ack     = r_swap_ack;
`else
    assign o_prog_rd_addr = w_rd_addr_lo;
`endif

endmodule
